// File: rtl/utils_pkg.sv
// -----------------------------------------------------------------------------
// utils_pkg
// Shared definitions for the pe_wbank processing element:
//   - default parameter widths/depths used by pe_wbank and pe_wgt_fifo
//   - width helpers for the weight-bank pointers and occupancy count
// No ports (package).
// -----------------------------------------------------------------------------
package utils_pkg;

  localparam int DEF_ID_WIDTH       = 6;
  localparam int DEF_IN_DATA_WIDTH  = 8;
  localparam int DEF_OUT_DATA_WIDTH = 24;
  localparam int DEF_WGT_DEPTH      = 4;

  // Pointer width for a power-of-two bank of 'depth' entries.
  function automatic int pe_wbank_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: one extra bit so that 'depth' itself (full) is representable.
  function automatic int pe_wbank_cnt_w(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/pe_wgt_fifo.sv
// -----------------------------------------------------------------------------
// pe_wgt_fifo
// Weight bank for pe_wbank: a circular buffer with write/read pointers and an
// occupancy count. Storage is intentionally not reset; only pointers and count
// are cleared, which discards any queued weights.
//
// The caller guarantees push is only asserted when there is room (or a pop
// happens in the same cycle) and pop only when cnt > 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   push       in   write push_data at the write pointer
//   push_data  in   DATA_WIDTH  weight to store
//   pop        in   advance the read pointer
//   pop_data   out  DATA_WIDTH  entry at the read pointer (combinational)
//   cnt        out  CNT_W       number of stored weights (registered)
// -----------------------------------------------------------------------------
module pe_wgt_fifo
  import utils_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int DEPTH      = DEF_WGT_DEPTH,
  localparam int PTR_W     = pe_wbank_ptr_w(DEPTH),
  localparam int CNT_W     = pe_wbank_cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] bank_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push, pop})
      2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      cnt_r <= cnt_nxt_s;
    end
  end

  // Bank storage, deliberately without reset.
  always_ff @(posedge clk) begin
    if (push) begin
      bank_r[wr_ptr_r] <= push_data;
    end
  end

  // When full with push and pop together, wr_ptr == rd_ptr: the read below
  // returns the old entry because the write only lands at the clock edge.
  assign pop_data = bank_r[rd_ptr_r];
  assign cnt      = cnt_r;

endmodule

// File: rtl/pe_wbank.sv
// -----------------------------------------------------------------------------
// pe_wbank
// Systolic-array processing element with a local weight bank.
//   - Load bus: beats addressed to ID_VAL are captured into the weight bank
//     (when there is room); every other beat, and any addressed beat that
//     could not be stored, is forwarded downstream with 1-cycle latency.
//   - Pop: each i_pop_vld consumes one weight (or 0 when empty) and starts a
//     MAC  o_down_data = i_left_data * i_up_data + weight, 3 cycles later.
//   - o_right_data is i_left_data delayed by one cycle.
//   - o_ovf / o_unf are sticky until reset.
//
// Configuration macro: PE_WBANK_SIGNED_EN
//   defined   -> left, up and weight are two's complement (sign-extended)
//   undefined -> unsigned arithmetic, weight zero-extended
// In both cases the product and the sum wrap modulo 2^OUT_DATA_WIDTH.
// OUT_DATA_WIDTH must be larger than IN_DATA_WIDTH.
//
// Ports:
//   clk, rst                          clock / synchronous active-high reset
//   i_load_vld/i_load_id/i_load_data  load bus in
//   o_load_vld/o_load_id/o_load_data  load bus out (registered)
//   i_pop_vld                         consume one weight, start one MAC
//   o_pop_vld                         i_pop_vld delayed 3 cycles
//   i_up_data, i_left_data            MAC operands
//   o_right_data, o_down_data         systolic outputs
//   o_wgt_cnt, o_full, o_empty        bank occupancy
//   o_ovf, o_unf                      sticky overflow / underflow
// -----------------------------------------------------------------------------
module pe_wbank
  import utils_pkg::*;
#(
  parameter int ID_VAL         = 0,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
  parameter int WGT_DEPTH      = DEF_WGT_DEPTH,
  localparam int CNT_W         = pe_wbank_cnt_w(WGT_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load_vld,
  input  logic [ID_WIDTH-1:0]       i_load_id,
  input  logic [IN_DATA_WIDTH-1:0]  i_load_data,
  output logic                      o_load_vld,
  output logic [ID_WIDTH-1:0]       o_load_id,
  output logic [IN_DATA_WIDTH-1:0]  o_load_data,
  input  logic                      i_pop_vld,
  output logic                      o_pop_vld,
  input  logic [OUT_DATA_WIDTH-1:0] i_up_data,
  input  logic [IN_DATA_WIDTH-1:0]  i_left_data,
  output logic [IN_DATA_WIDTH-1:0]  o_right_data,
  output logic [OUT_DATA_WIDTH-1:0] o_down_data,
  output logic [CNT_W-1:0]          o_wgt_cnt,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_ovf,
  output logic                      o_unf
);

  localparam int EXT_W = OUT_DATA_WIDTH - IN_DATA_WIDTH;

  logic                      hit_s;
  logic                      pop_ok_s;
  logic                      accept_s;
  logic [IN_DATA_WIDTH-1:0]  fifo_rd_data_s;
  logic [IN_DATA_WIDTH-1:0]  addend_s;

  logic                      s1_vld_r;
  logic [IN_DATA_WIDTH-1:0]  s1_left_r;
  logic [OUT_DATA_WIDTH-1:0] s1_up_r;
  logic [IN_DATA_WIDTH-1:0]  s1_addend_r;

  logic [OUT_DATA_WIDTH-1:0] left_ext_s;
  logic [OUT_DATA_WIDTH-1:0] addend_ext_s;
  logic [OUT_DATA_WIDTH-1:0] mac_s;

  logic                      s2_vld_r;
  logic [OUT_DATA_WIDTH-1:0] s2_sum_r;

  // Weight bank: pointers, count and storage.
  pe_wgt_fifo #(
    .DATA_WIDTH (IN_DATA_WIDTH),
    .DEPTH      (WGT_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (accept_s),
    .push_data  (i_load_data),
    .pop        (pop_ok_s),
    .pop_data   (fifo_rd_data_s),
    .cnt        (o_wgt_cnt)
  );

  assign o_full  = (o_wgt_cnt == CNT_W'(WGT_DEPTH));
  assign o_empty = (o_wgt_cnt == {CNT_W{1'b0}});

  // Load acceptance and addend selection. A full bank still accepts a beat
  // when a pop frees an entry in the same cycle.
  always_comb begin
    hit_s    = i_load_vld && (i_load_id == ID_WIDTH'(ID_VAL));
    pop_ok_s = i_pop_vld && !o_empty;
    accept_s = hit_s && (!o_full || pop_ok_s);
    if (pop_ok_s) begin
      addend_s = fifo_rd_data_s;
    end else begin
      addend_s = {IN_DATA_WIDTH{1'b0}};
    end
  end

  // Load-bus forwarding: consumed beats are dropped, all others pass through.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_load_vld  <= 1'b0;
      o_load_id   <= {ID_WIDTH{1'b0}};
      o_load_data <= {IN_DATA_WIDTH{1'b0}};
    end else begin
      o_load_vld  <= i_load_vld && !accept_s;
      o_load_id   <= i_load_id;
      o_load_data <= i_load_data;
    end
  end

  // Sticky overflow (addressed beat rejected) and underflow (pop when empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ovf <= 1'b0;
      o_unf <= 1'b0;
    end else begin
      if (hit_s && !accept_s) begin
        o_ovf <= 1'b1;
      end
      if (i_pop_vld && o_empty) begin
        o_unf <= 1'b1;
      end
    end
  end

  // Left operand passes right after one cycle regardless of pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_right_data <= {IN_DATA_WIDTH{1'b0}};
    end else begin
      o_right_data <= i_left_data;
    end
  end

  // MAC stage 1: capture operands and addend for each pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r    <= 1'b0;
      s1_left_r   <= {IN_DATA_WIDTH{1'b0}};
      s1_up_r     <= {OUT_DATA_WIDTH{1'b0}};
      s1_addend_r <= {IN_DATA_WIDTH{1'b0}};
    end else begin
      s1_vld_r <= i_pop_vld;
      if (i_pop_vld) begin
        s1_left_r   <= i_left_data;
        s1_up_r     <= i_up_data;
        s1_addend_r <= addend_s;
      end
    end
  end

  // Operand extension and multiply-add. Only the low OUT_DATA_WIDTH bits are
  // kept, and those are identical for signed and unsigned multiplication once
  // the narrow operands are extended correctly.
  always_comb begin
`ifdef PE_WBANK_SIGNED_EN
    left_ext_s   = {{EXT_W{s1_left_r[IN_DATA_WIDTH-1]}}, s1_left_r};
    addend_ext_s = {{EXT_W{s1_addend_r[IN_DATA_WIDTH-1]}}, s1_addend_r};
`else
    left_ext_s   = {{EXT_W{1'b0}}, s1_left_r};
    addend_ext_s = {{EXT_W{1'b0}}, s1_addend_r};
`endif
    mac_s = (left_ext_s * s1_up_r) + addend_ext_s;
  end

  // MAC stage 2: register the multiply-add result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_r <= 1'b0;
      s2_sum_r <= {OUT_DATA_WIDTH{1'b0}};
    end else begin
      s2_vld_r <= s1_vld_r;
      if (s1_vld_r) begin
        s2_sum_r <= mac_s;
      end
    end
  end

  // MAC stage 3: output register; o_down_data holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_pop_vld   <= 1'b0;
      o_down_data <= {OUT_DATA_WIDTH{1'b0}};
    end else begin
      o_pop_vld <= s2_vld_r;
      if (s2_vld_r) begin
        o_down_data <= s2_sum_r;
      end
    end
  end

endmodule

// File: tb/tb_pe_wbank.sv
// -----------------------------------------------------------------------------
// tb_pe_wbank
// Self-checking bench for pe_wbank. A behavioural model (weight queue, sticky
// flags, result delay line) is updated at every rising edge from the inputs
// that edge sampled; all outputs are compared #1 later. Directed scenarios
// are followed by a randomized run with occasional resets.
// -----------------------------------------------------------------------------
module tb_pe_wbank;

  localparam int ID_VAL = 5;
  localparam int IDW    = 6;
  localparam int IW     = 8;
  localparam int OW     = 24;
  localparam int DEPTH  = 4;
  localparam int CW     = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_load_vld;
  logic [IDW-1:0]  i_load_id;
  logic [IW-1:0]   i_load_data;
  logic            o_load_vld;
  logic [IDW-1:0]  o_load_id;
  logic [IW-1:0]   o_load_data;
  logic            i_pop_vld;
  logic            o_pop_vld;
  logic [OW-1:0]   i_up_data;
  logic [IW-1:0]   i_left_data;
  logic [IW-1:0]   o_right_data;
  logic [OW-1:0]   o_down_data;
  logic [CW-1:0]   o_wgt_cnt;
  logic            o_full;
  logic            o_empty;
  logic            o_ovf;
  logic            o_unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_wbank #(
    .ID_VAL         (ID_VAL),
    .ID_WIDTH       (IDW),
    .IN_DATA_WIDTH  (IW),
    .OUT_DATA_WIDTH (OW),
    .WGT_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_vld   (i_load_vld),
    .i_load_id    (i_load_id),
    .i_load_data  (i_load_data),
    .o_load_vld   (o_load_vld),
    .o_load_id    (o_load_id),
    .o_load_data  (o_load_data),
    .i_pop_vld    (i_pop_vld),
    .o_pop_vld    (o_pop_vld),
    .i_up_data    (i_up_data),
    .i_left_data  (i_left_data),
    .o_right_data (o_right_data),
    .o_down_data  (o_down_data),
    .o_wgt_cnt    (o_wgt_cnt),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_ovf        (o_ovf),
    .o_unf        (o_unf)
  );

  // ---------------- reference model state ----------------
  logic [IW-1:0]  wq[$];
  logic           m_ovf, m_unf;
  logic           m_lv;
  logic [IDW-1:0] m_lid;
  logic [IW-1:0]  m_ldata;
  logic [IW-1:0]  m_right;
  logic           m_pv;
  logic [OW-1:0]  m_down;
  logic           m_hv[2];
  logic [OW-1:0]  m_hr[2];

  function automatic logic [OW-1:0] ref_mac(input logic [IW-1:0] l,
                                            input logic [OW-1:0] u,
                                            input logic [IW-1:0] w);
    longint li, ui, wi, r;
`ifdef PE_WBANK_SIGNED_EN
    li = longint'($signed(l));
    ui = longint'($signed(u));
    wi = longint'($signed(w));
`else
    li = longint'(l);
    ui = longint'(u);
    wi = longint'(w);
`endif
    r = li * ui + wi;
    return r[OW-1:0];
  endfunction

  task automatic model_clock();
    logic          hit, pop_ok, acc;
    logic [IW-1:0] add;
    if (rst) begin
      wq.delete();
      m_ovf = 1'b0; m_unf = 1'b0;
      m_lv = 1'b0; m_lid = '0; m_ldata = '0; m_right = '0;
      m_pv = 1'b0; m_down = '0;
      m_hv[0] = 1'b0; m_hv[1] = 1'b0; m_hr[0] = '0; m_hr[1] = '0;
    end else begin
      hit    = i_load_vld && (i_load_id == IDW'(ID_VAL));
      pop_ok = i_pop_vld && (wq.size() > 0);
      acc    = hit && ((wq.size() < DEPTH) || pop_ok);
      add    = '0;
      if (pop_ok) add = wq.pop_front();
      if (acc) wq.push_back(i_load_data);
      if (hit && !acc) m_ovf = 1'b1;
      if (i_pop_vld && !pop_ok) m_unf = 1'b1;
      m_lv    = i_load_vld && !acc;
      m_lid   = i_load_id;
      m_ldata = i_load_data;
      m_right = i_left_data;
      // result of the pop taken two edges ago appears now (3-cycle latency)
      m_pv = m_hv[1];
      if (m_hv[1]) m_down = m_hr[1];
      m_hv[1] = m_hv[0];
      m_hr[1] = m_hr[0];
      m_hv[0] = i_pop_vld;
      m_hr[0] = ref_mac(i_left_data, i_up_data, add);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("load_vld",  32'(o_load_vld),   32'(m_lv));
    chk("load_id",   32'(o_load_id),    32'(m_lid));
    chk("load_data", 32'(o_load_data),  32'(m_ldata));
    chk("pop_vld",   32'(o_pop_vld),    32'(m_pv));
    chk("down_data", 32'(o_down_data),  32'(m_down));
    chk("right",     32'(o_right_data), 32'(m_right));
    chk("wgt_cnt",   32'(o_wgt_cnt),    32'(wq.size()));
    chk("full",      32'(o_full),       32'(wq.size() == DEPTH));
    chk("empty",     32'(o_empty),      32'(wq.size() == 0));
    chk("ovf",       32'(o_ovf),        32'(m_ovf));
    chk("unf",       32'(o_unf),        32'(m_unf));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic drive(input logic lv, input logic [IDW-1:0] id, input logic [IW-1:0] d,
                       input logic pv, input logic [IW-1:0] l, input logic [OW-1:0] u);
    i_load_vld  = lv;
    i_load_id   = id;
    i_load_data = d;
    i_pop_vld   = pv;
    i_left_data = l;
    i_up_data   = u;
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 8'd0, 1'b0, 8'd0, 24'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [OW-1:0] exp_sgn;

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_cnt",   32'(o_wgt_cnt), 32'd0);

    // load 3,5 then two MACs: 2*10+3 = 23, 1*1+5 = 6
    drive(1'b1, IDW'(ID_VAL), 8'd3, 1'b0, 8'd0, 24'd0); step();
    drive(1'b1, IDW'(ID_VAL), 8'd5, 1'b0, 8'd0, 24'd0); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd2, 24'd10); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd1, 24'd1);  step();
    idle(); step();
    chk("mac23_vld", 32'(o_pop_vld), 32'd1);
    chk("mac23",     32'(o_down_data), 32'd23);
    step();
    chk("mac6_vld",  32'(o_pop_vld), 32'd1);
    chk("mac6",      32'(o_down_data), 32'd6);
    step();

    // pop while empty: 4*4+0 = 16, underflow flagged
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd4, 24'd4); step();
    idle(); step(); step();
    chk("unf_mac16", 32'(o_down_data), 32'd16);
    chk("unf_flag",  32'(o_unf), 32'd1);
    chk("unf_cnt",   32'(o_wgt_cnt), 32'd0);

    // 5 loads into a 4-deep bank
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, IDW'(ID_VAL), IW'(8'h10 + i), 1'b0, 8'd0, 24'd0); step();
    end
    chk("ovf_full", 32'(o_full), 32'd1);
    drive(1'b1, IDW'(ID_VAL), 8'h55, 1'b0, 8'd0, 24'd0); step();
    chk("ovf_fwd",  32'(o_load_vld), 32'd1);
    chk("ovf_flag", 32'(o_ovf), 32'd1);
    chk("ovf_cnt",  32'(o_wgt_cnt), 32'd4);

    // full bank: hit + pop together, then a beat for another PE
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, IDW'(ID_VAL), IW'(8'h20 + i), 1'b0, 8'd0, 24'd0); step();
    end
    drive(1'b1, IDW'(ID_VAL), 8'h77, 1'b1, 8'd1, 24'd1); step();
    chk("fp_lv",  32'(o_load_vld), 32'd0);
    chk("fp_cnt", 32'(o_wgt_cnt), 32'd4);
    chk("fp_ovf", 32'(o_ovf), 32'd0);
    drive(1'b1, IDW'(ID_VAL + 1), 8'hA5, 1'b0, 8'd0, 24'd0); step();
    chk("mis_lv",   32'(o_load_vld), 32'd1);
    chk("mis_id",   32'(o_load_id), 32'(ID_VAL + 1));
    chk("mis_data", 32'(o_load_data), 32'h0000_00A5);
    idle(); step(); step();

    // weight 0xFF, left 0xFE, up 3
    do_reset();
    drive(1'b1, IDW'(ID_VAL), 8'hFF, 1'b0, 8'd0, 24'd0); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'hFE, 24'd3); step();
    idle(); step(); step();
`ifdef PE_WBANK_SIGNED_EN
    exp_sgn = 24'hFFFFF9;   // -2*3 + -1
`else
    exp_sgn = 24'h0003F9;   // 254*3 + 255
`endif
    chk("sign_mac", 32'(o_down_data), 32'(exp_sgn));

    // reset with MACs in flight
    do_reset();
    drive(1'b1, IDW'(ID_VAL), 8'd9, 1'b0, 8'd0, 24'd0); step();
    drive(1'b1, IDW'(ID_VAL), 8'd7, 1'b0, 8'd0, 24'd0); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd3, 24'd3); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd2, 24'd2); step();
    drive(1'b0, 6'd0, 8'd0, 1'b1, 8'd1, 24'd1); step();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstf_pv", 32'(o_pop_vld), 32'd0);
    end
    chk("rstf_cnt", 32'(o_wgt_cnt), 32'd0);
    chk("rstf_unf", 32'(o_unf), 32'd0);
    chk("rstf_ovf", 32'(o_ovf), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 63) == 0);
      i_load_vld  = ($urandom_range(0, 9) < 6);
      i_load_id   = ($urandom_range(0, 3) == 0) ? IDW'(ID_VAL + 1) : IDW'(ID_VAL);
      i_load_data = IW'($urandom);
      i_pop_vld   = ($urandom_range(0, 9) < 4);
      i_left_data = IW'($urandom);
      i_up_data   = OW'($urandom);
      step();
    end
    rst = 1'b0;
    idle();
    step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
